// File: rtl/pipe_stage_reg_n_if.sv
// Signal bundle between a datapath stage and pipe_stage_reg_n.
// The master side drives the stage inputs; the slave side is the register chain.
interface pipe_stage_reg_n_if #(
    parameter int DATA_W = 128,
    parameter int NSTAGE = 1,
    parameter int LD_W   = 32
);
    localparam int OCC_W = $clog2(NSTAGE + 1);

    logic              enable;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_halt;
    logic              mem_hit;
    logic [LD_W-1:0]   mem_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [LD_W-1:0]   out_ld;
    logic              out_halt;
    logic [OCC_W-1:0]  occupancy;
    logic [31:0]       stall_cnt;

    modport master (
        output enable, flush, in_valid, in_data, in_halt, mem_hit, mem_data,
        input  out_valid, out_data, out_ld, out_halt, occupancy, stall_cnt
    );

    modport slave (
        input  enable, flush, in_valid, in_data, in_halt, mem_hit, mem_data,
        output out_valid, out_data, out_ld, out_halt, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg_n.sv
// N-deep pipeline register chain with valid tracking, stall, flush, sticky halt and load-data hold.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_reg_n #(
    parameter int DATA_W = 128,
    parameter int NSTAGE = 1,
    parameter int LD_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    pipe_stage_reg_n_if.slave bus
);
    localparam int OCC_W = $clog2(NSTAGE + 1);
    localparam int LAST  = NSTAGE - 1;

    logic              valid_q [NSTAGE];
    logic              valid_d [NSTAGE];
    logic [DATA_W-1:0] data_q  [NSTAGE];
    logic [DATA_W-1:0] data_d  [NSTAGE];
    logic [LD_W-1:0]   ld_q    [NSTAGE];
    logic [LD_W-1:0]   ld_d    [NSTAGE];
    logic              halt_q  [NSTAGE];
    logic              halt_d  [NSTAGE];

    logic              hold_full_q, hold_full_d;
    logic [LD_W-1:0]   hold_data_q, hold_data_d;
    logic              out_halt_q, out_halt_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [LD_W-1:0]   ld_src;

    always_comb begin
        ld_src      = bus.mem_hit ? bus.mem_data : (hold_full_q ? hold_data_q : '0);
        valid_d     = valid_q;
        data_d      = data_q;
        ld_d        = ld_q;
        halt_d      = halt_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        out_halt_d  = out_halt_q;

        if (bus.flush) begin
            for (int k = 0; k < NSTAGE; k++) begin
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
                ld_d[k]    = '0;
                halt_d[k]  = 1'b0;
            end
            hold_full_d = 1'b0;
            hold_data_d = '0;
        end else if (bus.enable) begin
            for (int k = 1; k < NSTAGE; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = data_q[k-1];
                ld_d[k]    = ld_q[k-1];
                halt_d[k]  = halt_q[k-1];
            end
            valid_d[0]  = bus.in_valid;
            data_d[0]   = bus.in_data;
            ld_d[0]     = ld_src;
            halt_d[0]   = bus.in_halt;
            hold_full_d = 1'b0;
            hold_data_d = '0;
            // halt latches on the shift into the output stage, valid or not
            if (halt_d[LAST]) out_halt_d = 1'b1;
        end else if (bus.mem_hit) begin
            hold_full_d = 1'b1;
            hold_data_d = bus.mem_data;
        end

        occ_d = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < NSTAGE; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                ld_q[k]    <= '0;
                halt_q[k]  <= 1'b0;
            end
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            out_halt_q  <= 1'b0;
            occ_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            ld_q        <= ld_d;
            halt_q      <= halt_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            out_halt_q  <= out_halt_d;
            occ_q       <= occ_d;
        end
    end

    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
    assign bus.out_ld    = ld_q[LAST];
    assign bus.out_halt  = out_halt_q;
    assign bus.occupancy = occ_q;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!bus.enable && !bus.flush && valid_q[0] && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) stall_cnt_q <= 32'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg_n.sv
// Scoreboard bench for pipe_stage_reg_n: stimulus pushes expected outputs, a monitor pops and compares.
module tb_pipe_stage_reg_n;
    localparam int DW = 32;
    localparam int N  = 3;
    localparam int LW = 32;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    pipe_stage_reg_n_if #(.DATA_W(DW), .NSTAGE(N), .LD_W(LW)) bus ();
    pipe_stage_reg_n #(.DATA_W(DW), .NSTAGE(N), .LD_W(LW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    typedef struct { bit v; bit [DW-1:0] d; bit [LW-1:0] ld; bit h; } ent_t;
    typedef struct { bit v; bit [DW-1:0] d; bit [LW-1:0] ld; bit halt; int occ; bit [31:0] scnt; } exp_t;

    ent_t        pipe [N];
    bit          m_halt;
    bit [LW-1:0] hold_d;
    bit [31:0]   m_scnt;
    exp_t        expq [$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) pipe[k] = '{1'b0, '0, '0, 1'b0};
        m_halt = 1'b0;
        hold_d = '0;
        m_scnt = '0;
    endtask

    function automatic int model_occ();
        int c = 0;
        for (int k = 0; k < N; k++) c += pipe[k].v ? 1 : 0;
        return c;
    endfunction

    task automatic idle_inputs();
        bus.enable = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_halt = 1'b0; bus.mem_hit = 1'b0; bus.mem_data = '0;
    endtask

    // One clock of stimulus: drive at negedge, advance the reference, queue the expected outputs.
    task automatic step(input bit en, input bit fl, input bit iv, input bit [DW-1:0] id,
                        input bit ih, input bit mh, input bit [LW-1:0] md);
        exp_t e;
        @(negedge CLK);
        bus.enable = en; bus.flush = fl; bus.in_valid = iv; bus.in_data = id;
        bus.in_halt = ih; bus.mem_hit = mh; bus.mem_data = md;
`ifdef PIPE_STALL_CNT_EN
        if (!en && !fl && pipe[0].v && m_scnt != 32'hFFFF_FFFF) m_scnt++;
`endif
        if (fl) begin
            for (int k = 0; k < N; k++) pipe[k] = '{1'b0, '0, '0, 1'b0};
            hold_d = '0;
        end else if (en) begin
            for (int k = N - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = '{iv, id, (mh ? md : hold_d), ih};
            hold_d  = '0;
            if (pipe[N-1].h) m_halt = 1'b1;
        end else if (mh) begin
            hold_d = md;
        end
        e = '{pipe[N-1].v, pipe[N-1].d, pipe[N-1].ld, m_halt, model_occ(), m_scnt};
        expq.push_back(e);
    endtask

    task automatic rand_steps(input int n, input int halt_den);
        for (int i = 0; i < n; i++)
            step(($urandom_range(3) != 0), ($urandom_range(15) == 0), $urandom_range(1), $urandom,
                 (halt_den > 0) && ($urandom_range(halt_den - 1) == 0), ($urandom_range(2) == 0), $urandom);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out_valid", bus.out_valid, e.v);
                chk("out_data",  bus.out_data,  e.d);
                chk("out_ld",    bus.out_ld,    e.ld);
                chk("out_halt",  bus.out_halt,  e.halt);
                chk("occupancy", bus.occupancy, e.occ);
                chk("stall_cnt", bus.stall_cnt, e.scnt);
            end
        end
    end

    initial begin : stim
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_ld",    bus.out_ld,    0);
        chk("rst_out_halt",  bus.out_halt,  0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // fill latency
        step(1, 0, 1, 32'hA5, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);

        // hit during stall is held and consumed on the next advance
        step(1, 0, 1, 32'h11, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h1234);
        repeat (4) step(0, 0, 0, 0, 0, 0, 32'hDEAD);
        step(1, 0, 1, 32'h22, 0, 0, 32'hBEEF);
        step(1, 0, 1, 32'h33, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);

        // last hit wins
        step(0, 0, 0, 0, 0, 1, 32'h5555);
        step(0, 0, 0, 0, 0, 1, 32'h6666);
        repeat (3) step(1, 0, 1, 32'h44, 0, 0, 0);

        // flush beats enable
        step(1, 1, 1, 32'h77, 0, 1, 32'h99);
        step(1, 0, 0, 0, 0, 0, 0);

        rand_steps(300, 0);

        // sticky halt survives flush and continued advance
        step(1, 0, 1, 32'hC0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 1, $urandom, 0, 0, 0);

        // async reset with a full chain
        repeat (3) step(1, 0, 1, $urandom, 0, 1, $urandom);
        @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_occupancy", bus.occupancy, 0);
        chk("arst_out_halt",  bus.out_halt,  0);
        chk("arst_out_data",  bus.out_data,  0);
        chk("arst_stall_cnt", bus.stall_cnt, 0);
        idle_inputs();
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;

        rand_steps(250, 32);

        repeat (4) @(posedge CLK);
        #3;
        chk("drain", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
